// File: rtl/hog_pkg.sv
// Shared constants and types for the HOG window pipeline: pyramid-level
// window generators, the level window arbiter and the window serializer.
package hog_pkg;

    localparam int NUM_LEVELS   = 4;
    localparam int WINDOW_WIDTH = 1152;
    localparam int META_WIDTH   = 3;
    localparam int CNT_WIDTH    = 16;

    // Occupancy of a one-entry output register.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } win_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. The search starts one past 'last' and
// wraps, so the most recently served requester has the lowest priority.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    // Scan from last+1 upward (mod N); the first pending requester wins.
    always_comb begin
        int          cand;
        logic [IW-1:0] cand_idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= N; i++) begin
            cand     = (int'(last) + i) % N;
            cand_idx = IW'(cand);
            if (!any && req[cand_idx]) begin
                any             = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/level_window_arbiter.sv
// Shares one window serializer among the pyramid-level window generators.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never waits on ready, and once out_valid is raised the
// window and metadata hold until out_ready takes them.
module level_window_arbiter
    import hog_pkg::*;
#(
    parameter int NUM_LEVELS   = hog_pkg::NUM_LEVELS,
    parameter int WINDOW_WIDTH = hog_pkg::WINDOW_WIDTH,
    parameter int META_WIDTH   = hog_pkg::META_WIDTH,
    parameter int CNT_WIDTH    = hog_pkg::CNT_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             sof,
    input  logic [NUM_LEVELS-1:0]            req_valid,
    input  logic [NUM_LEVELS*WINDOW_WIDTH-1:0] req_window,
    output logic [NUM_LEVELS-1:0]            req_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WINDOW_WIDTH-1:0]          out_window,
    output logic [META_WIDTH-1:0]            out_metadata,
    output logic [CNT_WIDTH-1:0]             win_count
);

    localparam int IW = $clog2(NUM_LEVELS);
    localparam logic [IW-1:0] LAST_INIT = IW'(NUM_LEVELS - 1);

    win_state_e              state_q, state_d;
    logic [WINDOW_WIDTH-1:0] window_q, window_d;
    logic [META_WIDTH-1:0]   meta_q, meta_d;
    logic [IW-1:0]           last_grant_q, last_grant_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

    logic [NUM_LEVELS-1:0]   grant;
    logic [IW-1:0]           grant_idx;
    logic                    grant_any;
    logic                    load_en;
    logic                    accept;
    logic                    handshake;

    rr_arbiter #(.N(NUM_LEVELS)) u_rr (
        .req       (req_valid),
        .last      (last_grant_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    assign out_valid    = (state_q == ST_FULL);
    assign out_window   = window_q;
    assign out_metadata = meta_q;
    assign win_count    = cnt_q;

    // The register may load when empty or when it drains this same cycle.
    // Grants are gated by rst_n so nothing is accepted while in reset.
    assign load_en   = !out_valid || out_ready;
    assign req_ready = grant & {NUM_LEVELS{load_en & rst_n}};
    assign accept    = grant_any && load_en;
    assign handshake = out_valid && out_ready;

    // Next-state: load/drain of the output register, pointer and counter.
    always_comb begin
        state_d      = state_q;
        window_d     = window_q;
        meta_d       = meta_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;

        if (accept) begin
            window_d     = req_window[grant_idx*WINDOW_WIDTH +: WINDOW_WIDTH];
            meta_d       = META_WIDTH'(grant_idx);
            last_grant_d = grant_idx;
            state_d      = ST_FULL;
        end else if (handshake) begin
            state_d = ST_EMPTY;
        end

        if (handshake && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        // Start of frame overrides both the pointer update and the count,
        // but leaves a held window in place.
        if (sof) begin
            last_grant_d = LAST_INIT;
            cnt_d        = '0;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            window_q     <= '0;
            meta_q       <= '0;
            last_grant_q <= LAST_INIT;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            window_q     <= window_d;
            meta_q       <= meta_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: doc/level_window_arbiter.md
# level_window_arbiter

Shares the single window serializer among the per-pyramid-level window generators. Each cycle in which its output register can load, it picks one pending level window by round-robin, captures the window, and tags it with the level index as metadata. It then presents the window to the serializer through a valid/ready handshake. It sits between the per-level window buffers and the serializer's window input, and also keeps a per-frame count of windows forwarded.

## Interface
- NUM_LEVELS, 4, number of requesting pyramid levels; 2..2^META_WIDTH
- WINDOW_WIDTH, 1152, bits per window
- META_WIDTH, 3, metadata width; carries the level index
- CNT_WIDTH, 16, window counter width
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sof  in  1  start-of-frame pulse; restarts priority at level 0 and clears win_count
- req_valid  in  NUM_LEVELS  per-level window pending
- req_window  in  NUM_LEVELS*WINDOW_WIDTH  level i window at [i*WINDOW_WIDTH +: WINDOW_WIDTH]
- req_ready  out  NUM_LEVELS  one-hot grant; level i window accepted when req_valid[i] && req_ready[i]
- out_valid  out  1  registered window available; connects to serializer window_valid
- out_ready  in  1  serializer window_ready
- out_window  out  WINDOW_WIDTH  registered granted window
- out_metadata  out  META_WIDTH  registered granted level index
- win_count  out  CNT_WIDTH  windows delivered since last sof/reset; saturating

## Operation
- **State.** One-entry output register with two states.
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
  - load_en = !out_valid || out_ready. Loading is permitted when the register is empty or is being drained in the same cycle.
- **Arbitration.** Combinational round-robin over req_valid, starting at (last_grant+1) mod NUM_LEVELS.
  - req_ready = grant one-hot & {NUM_LEVELS{load_en}}.
  - req_ready is all-zero when no req_valid is set, or while rst_n is low (combinationally gated).
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- **Load.** When any grant is accepted:
  - out_window <= granted window; out_metadata <= granted index.
  - last_grant <= granted index; state -> FULL.
- **Drain.** On out_valid && out_ready with no new grant, state -> EMPTY. out_window and out_metadata hold their last values.
- **Simultaneous drain and load.** The register reloads and stays FULL, with no bubble.
- **Counting.** win_count increments on every out_valid && out_ready and saturates at all-ones.
- **sof.**
  - last_grant <= NUM_LEVELS-1, so level 0 has top priority at the next arbitration; win_count <= 0.
  - A grant in the same cycle as sof uses the old pointer, but sof's pointer value overrides that grant's update.
  - sof together with a handshake: the clear wins, so win_count = 0.
  - sof does not discard the FULL register.
- **Level indices.** Indices ≥ NUM_LEVELS never appear on out_metadata.

## Timing
- Reset values: out_valid=0, out_window=0, out_metadata=0, win_count=0, last_grant=NUM_LEVELS-1, req_ready=0.
- Latency: a request accepted in cycle T appears on out_valid/out_window in cycle T+1.
- Throughput: at most one window per cycle. The serializer paces delivery at one per 10 cycles for the default widths.
- Holding rule: while out_valid=1 and out_ready=0, out_window and out_metadata are stable and req_ready=0.
- Reset mid-operation: any pending window is lost. Requesters must re-present after reset release.

## Structure
- Shared package hog_pkg holds WINDOW_WIDTH, META_WIDTH, NUM_LEVELS defaults and the CNT_WIDTH constant, shared with the serializer and window generators.
- Sub-module rr_arbiter (parameter N): combinational round-robin picker.
  - Inputs: req[N], last[$clog2(N)].
  - Outputs: grant one-hot, grant_idx, any.
  - Reused later by other shared resources.
- Top module holds the output register, FSM, pointer and counter.

## Test plan
- **Single request.** Reset, then req_valid=4'b0100 with window pattern A, out_ready=1.
  - Required: req_ready=4'b0100 in that cycle.
  - Next cycle: out_valid=1, out_metadata=2, out_window=A.
  - After the handshake: win_count=1.
- **Fairness.** All four levels continuously valid, out_ready=1.
  - Required: metadata sequence 0,1,2,3,0,1 on consecutive cycles.
  - After 6 handshakes: win_count=6.
- **Backpressure.** Hold out_ready=0 for 5 cycles with all levels valid.
  - Required: out_window stable, req_ready=0 throughout, no grant consumed.
  - Release out_ready: the next grant goes to (last+1).
- **Serializer in loop.** Connect the real serializer, all levels valid.
  - Required: one window accepted every 10 cycles, metadata rotating 0..3.
  - Every window must be reconstructed bit-exact from the stream.
- **sof.** Pulse sof after level 1 has been granted, with levels 0 and 2 pending.
  - Required: the next grant goes to level 0, not 2.
  - win_count=0 the cycle after sof, including when sof coincides with a handshake.
- **Reset mid-transfer.** Assert rst_n=0 while FULL and out_ready=0.
  - Required: out_valid=0 and req_ready=0 immediately (asynchronously).
  - After release: the first grant goes to level 0.
